pal_sync_gen: RTL



---
 rtl/pal_sync_gen.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pal_sync_gen.sv
// ----------------------------------------------------------------------------
// pal_sync_gen
// Raster timing generator for the PAL composite encoder and the framebuffer
// fetch path. A 1536-clock line / 312-line field raster is counted in the
// 24 MHz pixel domain; pseudo-interlace alternates 312- and 313-line fields.
//
// Ports
//   clk24         in   pixel clock
//   reset         in   asynchronous, active-high
//   en_i          in   run enable; low holds the raster at 0,0 and idles outputs
//   interlace_i   in   pseudo-interlace select, taken at each field wrap
//   tv_hs_o       out  hsync, active low
//   tv_vs_o       out  vsync, active low
//   tv_porch_o    out  high outside the active window
//   field_o       out  current field, 0 = even
//   x_o           out  active pixel index, 0 when blanked
//   y_o           out  active line index, 0 when blanked
//   line_req_o    out  one-cycle pulse at clock 0 of each active line
//   frame_start_o out  one-cycle pulse at clock 0 of line 0
// ----------------------------------------------------------------------------
module pal_sync_gen #(
   parameter int H_TOTAL      = 1536,
   parameter int H_SYNC       = 113,
   parameter int H_ACT_START  = 250,
   parameter int H_ACT_END    = 1498,
   parameter int V_TOTAL      = 312,
   parameter int V_SYNC_LINES = 3,
   parameter int V_ACT_START  = 23,
   parameter int V_ACT_END    = 310
) (
   input  logic        clk24,
   input  logic        reset,
   input  logic        en_i,
   input  logic        interlace_i,
   output logic        tv_hs_o,
   output logic        tv_vs_o,
   output logic        tv_porch_o,
   output logic        field_o,
   output logic [10:0] x_o,
   output logic [8:0]  y_o,
   output logic        line_req_o,
   output logic        frame_start_o
);

   localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_SYNC_C    = 11'(H_SYNC);
   localparam logic [10:0] H_ACT_S     = 11'(H_ACT_START);
   localparam logic [10:0] H_ACT_E     = 11'(H_ACT_END);
   localparam logic [8:0]  V_LAST      = 9'(V_TOTAL - 1);
   localparam logic [8:0]  V_LAST_LONG = 9'(V_TOTAL);
   localparam logic [8:0]  V_SYNC_C    = 9'(V_SYNC_LINES);
   localparam logic [8:0]  V_ACT_S     = 9'(V_ACT_START);
   localparam logic [8:0]  V_ACT_E     = 9'(V_ACT_END);

   logic [10:0] h_cnt;
   logic [8:0]  v_cnt;
   logic        lace_q;
   logic [8:0]  v_last;
   logic        h_wrap;
   logic        v_wrap;

   // The odd field of an interlaced pair carries the extra 313th line.
   always_comb begin
      v_last = (lace_q && field_o) ? V_LAST_LONG : V_LAST;
      h_wrap = (h_cnt == H_LAST);
      v_wrap = h_wrap && (v_cnt == v_last);
   end

   // ---- stage p0: raster counters and field state ----
   always_ff @(posedge clk24 or posedge reset) begin
      if (reset) begin
         h_cnt   <= '0;
         v_cnt   <= '0;
         field_o <= 1'b0;
         lace_q  <= 1'b0;
      end else if (!en_i) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_wrap) begin
         h_cnt <= '0;
         if (v_wrap) begin
            v_cnt   <= '0;
            lace_q  <= interlace_i;
            // Progressive mode always restarts on the even field.
            field_o <= interlace_i ? ~field_o : 1'b0;
         end else begin
            v_cnt <= v_cnt + 9'd1;
         end
      end else begin
         h_cnt <= h_cnt + 11'd1;
      end
   end

   logic        vld_p0;
   logic        h_act_p0;
   logic        v_act_p0;
   logic        active_p0;
   logic        hs_p0;
   logic        vs_p0;
   logic [10:0] x_p0;
   logic [8:0]  y_p0;
   logic        lr_p0;
   logic        fs_p0;

   // The same hsync pulse is used on vsync lines; the encoder's ~(hs^vs)
   // turns it into a broad pulse with one serration while keeping exactly
   // one hs falling edge per line.
   always_comb begin
      vld_p0    = en_i;
      h_act_p0  = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E);
      v_act_p0  = (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
      active_p0 = h_act_p0 && v_act_p0;
      hs_p0     = (h_cnt >= H_SYNC_C);
      vs_p0     = (v_cnt >= V_SYNC_C);
      x_p0      = active_p0 ? (h_cnt - H_ACT_S) : '0;
      y_p0      = active_p0 ? (v_cnt - V_ACT_S) : '0;
      // Pulsing at clock 0 gives the fetch logic H_ACT_START clocks of lead.
      lr_p0     = (h_cnt == '0) && v_act_p0;
      fs_p0     = (h_cnt == '0) && (v_cnt == '0);
   end

   // ---- stage p1: registered outputs, idle whenever the raster is stopped ----
   always_ff @(posedge clk24 or posedge reset) begin
      if (reset) begin
         tv_hs_o       <= 1'b1;
         tv_vs_o       <= 1'b1;
         tv_porch_o    <= 1'b1;
         x_o           <= '0;
         y_o           <= '0;
         line_req_o    <= 1'b0;
         frame_start_o <= 1'b0;
      end else if (!vld_p0) begin
         tv_hs_o       <= 1'b1;
         tv_vs_o       <= 1'b1;
         tv_porch_o    <= 1'b1;
         x_o           <= '0;
         y_o           <= '0;
         line_req_o    <= 1'b0;
         frame_start_o <= 1'b0;
      end else begin
         tv_hs_o       <= hs_p0;
         tv_vs_o       <= vs_p0;
         tv_porch_o    <= ~active_p0;
         x_o           <= x_p0;
         y_o           <= y_p0;
         line_req_o    <= lr_p0;
         frame_start_o <= fs_p0;
      end
   end

endmodule
